// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline go/stall controller.
// Stage indices run youngest (IF) to oldest (WB).
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STAGES_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 16;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

endpackage

// File: rtl/pipe_can_go_ctrl_if.sv
// Control bundle between the pipeline stages and the go/stall controller.
// master drives the requests, slave is the controller.
interface pipe_can_go_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
);

  logic [NUM_STAGES-1:0] in_OwnCanGo;
  logic                  in_Issue;
  logic [NUM_STAGES-1:0] in_Flush;
  logic                  in_CntClear;
  logic [NUM_STAGES-1:0] out_CanGo;
  logic [NUM_STAGES-1:0] out_Valid;
  logic                  out_IssueReady;
  logic                  out_Retire;
  logic [CNT_W-1:0]      out_StallCount;

  modport master (
    output in_OwnCanGo,
    output in_Issue,
    output in_Flush,
    output in_CntClear,
    input  out_CanGo,
    input  out_Valid,
    input  out_IssueReady,
    input  out_Retire,
    input  out_StallCount
  );

  modport slave (
    input  in_OwnCanGo,
    input  in_Issue,
    input  in_Flush,
    input  in_CntClear,
    output out_CanGo,
    output out_Valid,
    output out_IssueReady,
    output out_Retire,
    output out_StallCount
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Reset and clear both win over an increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_Inc,
  input  logic             in_Clear,
  output logic [WIDTH-1:0] out_Count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (in_Clear)
      count_d = '0;
    else if (in_Inc && !(&count_q))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign out_Count = count_q;

endmodule

// File: rtl/pipe_can_go_ctrl.sv
// Per-stage go/stall controller with bubble collapse,
// flush, and an issue-stall counter.
module pipe_can_go_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  pipe_can_go_ctrl_if.slave  bus
);

  logic [NUM_STAGES:0]   free;
  logic [NUM_STAGES-1:0] can_go;
  logic [NUM_STAGES-1:0] move;
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;

  assign free[NUM_STAGES] = 1'b1;

  // Oldest to youngest: a stage is free if empty or leaving.
  for (genvar i = NUM_STAGES - 1; i >= 0; i--) begin : g_chain
    assign can_go[i] = bus.in_OwnCanGo[i] & free[i+1];
    assign move[i]   = valid_q[i] & can_go[i];
    assign free[i]   = ~valid_q[i] | move[i];
  end

  // Flush only masks the next state, never the go chain.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = ~bus.in_Flush[0]
               & ((bus.in_Issue & free[0])
                 | (valid_q[0] & ~move[0]));
    for (int i = 1; i < NUM_STAGES; i++) begin
      valid_d[i] = ~bus.in_Flush[i]
                 & (move[i-1] | (valid_q[i] & ~move[i]));
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      valid_q <= '0;
    else
      valid_q <= valid_d;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clock     (clock),
    .reset     (reset),
    .in_Inc    (bus.in_Issue & ~free[0]),
    .in_Clear  (bus.in_CntClear),
    .out_Count (bus.out_StallCount)
  );

  assign bus.out_CanGo      = can_go;
  assign bus.out_Valid      = valid_q;
  assign bus.out_IssueReady = free[0];
  assign bus.out_Retire     = move[NUM_STAGES-1];

endmodule

// File: tb/tb_pipe_can_go_ctrl.sv
// Bench for pipe_can_go_ctrl: directed scenarios plus a random
// run, both scored against a reference model through a queue.
module tb_pipe_can_go_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_can_go_ctrl_if #(.NUM_STAGES(5), .CNT_W(16)) if_a ();
  pipe_can_go_ctrl_if #(.NUM_STAGES(5), .CNT_W(4))  if_b ();

  pipe_can_go_ctrl #(.NUM_STAGES(5), .CNT_W(16)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (if_a.slave)
  );

  pipe_can_go_ctrl #(.NUM_STAGES(5), .CNT_W(4)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (if_b.slave)
  );

  typedef struct {
    logic [4:0]  cg;
    logic        rdy;
    logic        ret;
    logic [4:0]  val;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [4:0]  m_v = '0;
  int unsigned m_c = 0;

  logic [4:0] o_cg;
  logic       o_rdy;
  logic       o_ret;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int unsigned sat4(input int unsigned c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic step(input logic       r,
                      input logic [4:0] own,
                      input logic       iss,
                      input logic [4:0] fl,
                      input logic       clr);
    exp_t       e;
    exp_t       p;
    logic [4:0] cg;
    logic [4:0] mv;
    logic [4:0] nv;
    logic       f;
    rst = r;
    if_a.in_OwnCanGo = own; if_b.in_OwnCanGo = own;
    if_a.in_Issue    = iss; if_b.in_Issue    = iss;
    if_a.in_Flush    = fl;  if_b.in_Flush    = fl;
    if_a.in_CntClear = clr; if_b.in_CntClear = clr;
    f = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      cg[i] = own[i] & f;
      mv[i] = m_v[i] & cg[i];
      f     = ~m_v[i] | mv[i];
    end
    e.cg = cg; e.rdy = f; e.ret = mv[4];
    e.val = m_v; e.cnt = m_c;
    sb.push_back(e);
    #2;
    p = sb.pop_front();
    o_cg = if_a.out_CanGo;
    o_rdy = if_a.out_IssueReady;
    o_ret = if_a.out_Retire;
    chk("cg_a",  32'(if_a.out_CanGo),      32'(p.cg));
    chk("cg_b",  32'(if_b.out_CanGo),      32'(p.cg));
    chk("rdy_a", 32'(if_a.out_IssueReady), 32'(p.rdy));
    chk("ret_a", 32'(if_a.out_Retire),     32'(p.ret));
    chk("ret_b", 32'(if_b.out_Retire),     32'(p.ret));
    chk("val_a", 32'(if_a.out_Valid),      32'(p.val));
    chk("val_b", 32'(if_b.out_Valid),      32'(p.val));
    chk("cnt_a", 32'(if_a.out_StallCount), p.cnt);
    chk("cnt_b", 32'(if_b.out_StallCount), sat4(p.cnt));
    nv[0] = (iss & f) | (m_v[0] & ~mv[0]);
    for (int i = 1; i < 5; i++)
      nv[i] = mv[i-1] | (m_v[i] & ~mv[i]);
    nv = nv & ~fl;
    @(posedge clk);
    if (r) begin
      m_v = '0;
      m_c = 0;
    end else begin
      m_v = nv;
      if (clr)
        m_c = 0;
      else if (iss && !f && m_c < 65535)
        m_c = m_c + 1;
    end
    @(negedge clk);
  endtask

  task automatic fill();
    for (int k = 0; k < 5; k++)
      step(1'b0, 5'b11111, 1'b1, 5'b0, 1'b0);
  endtask

  logic [4:0] fill_exp [5] = '{5'b00001, 5'b00011, 5'b00111,
                               5'b01111, 5'b11111};
  logic [4:0] pat;

  initial begin
    rst = 1'b1;
    @(negedge clk);
    step(1'b1, 5'b0, 1'b0, 5'b0, 1'b0);
    step(1'b1, 5'b0, 1'b1, 5'b0, 1'b1);
    chk("rst_val", 32'(if_a.out_Valid), 32'd0);
    chk("rst_cnt", 32'(if_a.out_StallCount), 32'd0);
    chk("rst_rdy", 32'(if_a.out_IssueReady), 32'd1);
    chk("rst_ret", 32'(if_a.out_Retire), 32'd0);

    for (int k = 0; k < 5; k++) begin
      step(1'b0, 5'b11111, 1'b1, 5'b0, 1'b0);
      chk("fill_v", 32'(if_a.out_Valid), 32'(fill_exp[k]));
    end
    chk("fill_cnt", 32'(if_a.out_StallCount), 32'd0);
    step(1'b0, 5'b11111, 1'b1, 5'b0, 1'b0);
    chk("full_ret", 32'(o_ret), 32'd1);

    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'b01111, 1'b1, 5'b0, 1'b0);
      chk("wb_cg", 32'(o_cg), 32'd0);
      chk("wb_rdy", 32'(o_rdy), 32'd0);
    end
    chk("wb_cnt", 32'(if_a.out_StallCount), 32'd3);
    step(1'b0, 5'b01111, 1'b1, 5'b0, 1'b1);
    chk("clr_cnt", 32'(if_a.out_StallCount), 32'd0);

    step(1'b1, 5'b0, 1'b0, 5'b0, 1'b0);
    pat = 5'b10101;
    for (int k = 0; k < 5; k++)
      step(1'b0, 5'b11111, pat[k], 5'b0, 1'b0);
    chk("bub_v0", 32'(if_a.out_Valid), 32'(5'b10101));
    step(1'b0, 5'b01111, 1'b0, 5'b0, 1'b0);
    chk("bub_cg", 32'(o_cg), 32'(5'b00111));
    chk("bub_ret", 32'(o_ret), 32'd0);
    chk("bub_v1", 32'(if_a.out_Valid), 32'(5'b11010));

    step(1'b1, 5'b0, 1'b0, 5'b0, 1'b0);
    fill();
    step(1'b0, 5'b11111, 1'b1, 5'b00011, 1'b0);
    chk("fl_ret", 32'(o_ret), 32'd1);
    chk("fl_v", 32'(if_a.out_Valid), 32'(5'b11100));

    step(1'b1, 5'b0, 1'b0, 5'b0, 1'b0);
    fill();
    for (int k = 0; k < 20; k++)
      step(1'b0, 5'b01111, 1'b1, 5'b0, 1'b0);
    chk("sat_b", 32'(if_b.out_StallCount), 32'd15);
    chk("sat_a", 32'(if_a.out_StallCount), 32'd20);
    step(1'b0, 5'b01111, 1'b1, 5'b0, 1'b1);
    chk("sclr_b", 32'(if_b.out_StallCount), 32'd0);
    step(1'b0, 5'b01111, 1'b1, 5'b0, 1'b0);
    chk("sinc_b", 32'(if_b.out_StallCount), 32'd1);

    step(1'b1, 5'b01111, 1'b1, 5'b0, 1'b0);
    chk("rs_ret", 32'(o_ret), 32'd0);
    chk("rs_v", 32'(if_a.out_Valid), 32'd0);
    chk("rs_cnt", 32'(if_a.out_StallCount), 32'd0);
    step(1'b0, 5'b11111, 1'b0, 5'b0, 1'b0);
    chk("rs_ret2", 32'(o_ret), 32'd0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           5'($urandom | $urandom),
           1'($urandom),
           ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b0,
           ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
